fetch: RTL

Instruction fetch stage: owns the program counter, issues in-order word requests to instruction memory and buffers the returned instructions. It presents pc/instruction pairs to the decode stage over a valid/ready handshake. It sits between instruction memory and decode, and is the producer of decode's `pc_i`/`insn_i` inputs. A redirect input from execute reloads the PC and kills all younger instructions, including in-flight ones.

---
 rtl/fetch_if.sv | 62 ++++++
 rtl/fetch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// fetch_if: groups the instruction-memory, redirect and decode-side signals
// of the fetch stage into one bundle.
//
// Handshake rule (applies to imem_req_* and insn_*): a transfer happens on a
// rising clock edge where valid and ready are both high. The producer may not
// make its payload depend on that edge before it happens, and the consumer
// may drive ready independently of valid. imem_rsp_valid_i has no ready: the
// fetch stage always accepts a response.
//
// Signals:
//   imem_req_valid_o / imem_req_ready_i / imem_addr_o : request channel to memory
//   imem_rsp_valid_i / imem_rsp_data_i                : in-order response channel
//   redirect_i / redirect_pc_i                        : control-flow redirect from execute
//   insn_valid_o / insn_ready_i / pc_o / insn_o       : pc/instruction pairs toward decode
//
// Modports:
//   master : the fetch stage
//   slave  : the environment (memory, execute and decode)
interface fetch_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_rsp_valid_i;
  logic [DWIDTH-1:0] imem_rsp_data_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              insn_valid_o;
  logic              insn_ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;

  modport master (
    output imem_req_valid_o,
    input  imem_req_ready_i,
    output imem_addr_o,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    input  redirect_i,
    input  redirect_pc_i,
    output insn_valid_o,
    input  insn_ready_i,
    output pc_o,
    output insn_o
  );

  modport slave (
    input  imem_req_valid_o,
    output imem_req_ready_i,
    input  imem_addr_o,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    output redirect_i,
    output redirect_pc_i,
    input  insn_valid_o,
    output insn_ready_i,
    input  pc_o,
    input  insn_o
  );
endinterface

// File: rtl/fetch.sv
// fetch: instruction fetch stage. Owns the program counter, issues in-order
// word requests to instruction memory, tracks them in an in-flight queue and
// buffers the returned words in an output FIFO presented to decode.
// A redirect reloads the PC, flushes the output FIFO and marks every
// in-flight request as killed so its response is dropped on arrival.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_if.master (memory request/response, redirect, decode output)
//
// Parameters:
//   DWIDTH   : instruction width
//   AWIDTH   : address / PC width
//   BASEADDR : PC loaded by reset
//   DEPTH    : output FIFO entries and cap on in-flight + buffered (power of two, >= 2)
module fetch #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int                DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int PW = $clog2(DEPTH);   // pointer width
  localparam int CW = PW + 1;          // count width, holds 0..DEPTH
  localparam int SW = PW + 2;          // credit sum width, holds 0..2*DEPTH

  // Program counter of the next request
  logic [AWIDTH-1:0] r_fetch_pc;

  // In-flight queue: PC of each outstanding request plus its kill flag
  logic [AWIDTH-1:0] r_ifq_pc [DEPTH];
  logic [DEPTH-1:0]  r_ifq_kill;
  logic [PW-1:0]     r_ifq_rd;
  logic [PW-1:0]     r_ifq_wr;
  logic [CW-1:0]     r_ifq_cnt;

  // Output FIFO toward decode
  logic [AWIDTH-1:0] r_buf_pc   [DEPTH];
  logic [DWIDTH-1:0] r_buf_insn [DEPTH];
  logic [PW-1:0]     r_buf_rd;
  logic [PW-1:0]     r_buf_wr;
  logic [CW-1:0]     r_buf_cnt;

  logic              w_insn_valid;
  logic              w_pop;
  logic [SW-1:0]     w_credit_used;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp;
  logic              w_buf_push;

  // Outputs are forced low in the reset cycle even though the FIFO
  // registers still hold pre-reset contents until the edge.
  assign w_insn_valid = !rst && (r_buf_cnt != '0);
  assign w_pop        = w_insn_valid && bus.insn_ready_i;

  // Credit: every in-flight request already owns a FIFO slot, so the FIFO
  // can never overflow. An entry being consumed this cycle frees its slot
  // immediately, which is what lets a full pipe keep issuing one request per
  // cycle; this makes the request valid combinational on insn_ready_i.
  assign w_credit_used = SW'(r_ifq_cnt) + SW'(r_buf_cnt) - SW'(w_pop);
  assign w_req_valid   = !rst && !bus.redirect_i && (w_credit_used < SW'(DEPTH));
  assign w_req_fire    = w_req_valid && bus.imem_req_ready_i;

  // A response with nothing outstanding (e.g. one left over across a reset)
  // is ignored.
  assign w_rsp      = !rst && bus.imem_rsp_valid_i && (r_ifq_cnt != '0);
  // Killed entries and responses arriving in a redirect cycle are dropped.
  assign w_buf_push = w_rsp && !r_ifq_kill[r_ifq_rd] && !bus.redirect_i;

  assign bus.imem_req_valid_o = w_req_valid;
  assign bus.imem_addr_o      = r_fetch_pc;
  assign bus.insn_valid_o     = w_insn_valid;
  assign bus.pc_o             = w_insn_valid ? r_buf_pc[r_buf_rd]   : '0;
  assign bus.insn_o           = w_insn_valid ? r_buf_insn[r_buf_rd] : '0;

  // Control state: PC, pointers, counts and kill flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= BASEADDR;
      r_ifq_kill <= '0;
      r_ifq_rd   <= '0;
      r_ifq_wr   <= '0;
      r_ifq_cnt  <= '0;
      r_buf_rd   <= '0;
      r_buf_wr   <= '0;
      r_buf_cnt  <= '0;
    end else begin
      // PC: a redirect wins; the target is forced to word alignment
      if (bus.redirect_i) begin
        r_fetch_pc <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + AWIDTH'(4);
      end

      // In-flight queue. No request fires in a redirect cycle, so marking
      // every slot killed cannot hit a newly pushed entry; free slots get
      // their flag cleared again when they are next written.
      if (bus.redirect_i) begin
        r_ifq_kill <= '1;
      end else if (w_req_fire) begin
        r_ifq_kill[r_ifq_wr] <= 1'b0;
      end
      if (w_req_fire) begin
        r_ifq_wr <= r_ifq_wr + PW'(1);
      end
      if (w_rsp) begin
        r_ifq_rd <= r_ifq_rd + PW'(1);
      end
      r_ifq_cnt <= r_ifq_cnt + CW'(w_req_fire) - CW'(w_rsp);

      // Output FIFO: a redirect empties it regardless of push/pop
      if (bus.redirect_i) begin
        r_buf_rd  <= '0;
        r_buf_wr  <= '0;
        r_buf_cnt <= '0;
      end else begin
        if (w_buf_push) begin
          r_buf_wr <= r_buf_wr + PW'(1);
        end
        if (w_pop) begin
          r_buf_rd <= r_buf_rd + PW'(1);
        end
        r_buf_cnt <= r_buf_cnt + CW'(w_buf_push) - CW'(w_pop);
      end
    end
  end

  // Payload storage: no reset needed, validity is tracked by the counts
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_ifq_pc[r_ifq_wr] <= r_fetch_pc;
    end
    if (w_buf_push) begin
      r_buf_pc[r_buf_wr]   <= r_ifq_pc[r_ifq_rd];
      r_buf_insn[r_buf_wr] <= bus.imem_rsp_data_i;
    end
  end

endmodule
